// File: rtl/parity_frame_tx_pkg.sv
// Shared types and constants for the parity-protected serial word transmitter.
package parity_frame_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Bit slots in one frame: start + payload + parity + stop.
  function automatic int FRAME_BITS(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Word handshake between the producer (master) and the transmitter (slave).
interface parity_frame_tx_if #(parameter int DATA_W = 5) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/parity_frame_tx_bit_timer.sv
// Serial bit-slot timer: slot_end marks the last cycle of every BIT_CYCLES-long slot.
module bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic slot_end
);

  localparam int            TW   = $clog2(BIT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign slot_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || slot_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Frames a handshaken word as start(0), data LSB-first, parity, stop(1) on one serial line.
module parity_frame_tx #(
  parameter int DATA_W     = 5,
  parameter int PARITY_ODD = 0,
  parameter int BIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_frame_tx_if.slave     bus,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 frame_done
);
  import parity_frame_pkg::*;

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic          ODD_SEL  = (PARITY_ODD != 0) ? parity_frame_pkg::PARITY_ODD
                                                         : parity_frame_pkg::PARITY_EVEN;

  state_e            state_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] shift_q, shift_nx;
  logic              par_q, tx_q, busy_q;
  logic              slot_end, accept, timer_restart;

  // A new word may be taken in IDLE or in the final stop cycle, giving gap-free frames.
  assign bus.in_ready   = (state_q == IDLE) || ((state_q == STOP) && slot_end);
  assign accept         = bus.in_valid && bus.in_ready;
  assign frame_done     = (state_q == STOP) && slot_end;
  assign shift_nx       = shift_q >> 1;
  assign timer_restart  = (state_q == IDLE);
  assign tx_out         = tx_q;
  assign tx_busy        = busy_q;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (timer_restart),
    .slot_end (slot_end)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= bus.in_data;
      par_q   <= (^bus.in_data) ^ ODD_SEL;
    end else if ((state_q == DATA) && slot_end && (bit_cnt_q != LAST_BIT)) begin
      shift_q <= shift_nx;
    end
  end

  // tx_q is loaded with the value of the slot being entered, so the line is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
        START: if (slot_end) begin
          state_q   <= DATA;
          bit_cnt_q <= '0;
          tx_q      <= shift_q[0];
        end
        DATA: if (slot_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_q   <= PARITY;
            bit_cnt_q <= '0;
            tx_q      <= par_q;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            tx_q      <= shift_nx[0];
          end
        end
        PARITY: if (slot_end) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: if (slot_end) begin
          if (accept) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: default, odd-parity and 4-cycle-per-bit instances.
module tb_parity_frame_tx;
  import parity_frame_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parity_frame_tx_if #(.DATA_W(5)) if_a ();
  parity_frame_tx_if #(.DATA_W(5)) if_b ();
  parity_frame_tx_if #(.DATA_W(5)) if_c ();

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c;

  parity_frame_tx #(.DATA_W(5), .PARITY_ODD(0), .BIT_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .tx_out(tx_a), .tx_busy(busy_a), .frame_done(done_a));
  parity_frame_tx #(.DATA_W(5), .PARITY_ODD(1), .BIT_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .tx_out(tx_b), .tx_busy(busy_b), .frame_done(done_b));
  parity_frame_tx #(.DATA_W(5), .PARITY_ODD(0), .BIT_CYCLES(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave), .tx_out(tx_c), .tx_busy(busy_c), .frame_done(done_c));

  int n_chk = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    n_chk++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_a got=%b exp=1", tx_a); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a got=%b exp=0", done_a); end
    n_chk++; if (tx_b !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_b got=%b exp=1", tx_b); end
    n_chk++; if (tx_c !== 1'b1)   begin n_fail++; $display("FAIL reset_tx_c got=%b exp=1", tx_c); end
    n_chk++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL reset_busy_c got=%b exp=0", busy_c); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_chk++; if (if_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a got=%b exp=1", if_a.in_ready); end
    n_chk++; if (if_c.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_c got=%b exp=1", if_c.in_ready); end
  endtask

  task automatic test_frame_10110();
    logic [7:0] expv;
    expv = 8'b11101100;
    if_a.in_valid = 1'b1; if_a.in_data = 5'b10110;
    n_chk++; if (if_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL f10110_ready_idle got=%b exp=1", if_a.in_ready); end
    step();
    if_a.in_valid = 1'b0; if_a.in_data = 5'b00000;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (tx_a !== expv[i]) begin n_fail++; $display("FAIL f10110_tx[%0d] got=%b exp=%b", i, tx_a, expv[i]); end
      n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL f10110_busy[%0d] got=%b exp=1", i, busy_a); end
      n_chk++; if (done_a !== (i == 7)) begin n_fail++; $display("FAIL f10110_done[%0d] got=%b exp=%b", i, done_a, i == 7); end
      n_chk++; if (if_a.in_ready !== (i == 7)) begin n_fail++; $display("FAIL f10110_ready[%0d] got=%b exp=%b", i, if_a.in_ready, i == 7); end
      step();
    end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL f10110_busy_after got=%b exp=0", busy_a); end
    n_chk++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL f10110_tx_after got=%b exp=1", tx_a); end
  endtask

  task automatic test_frame_zero();
    logic [7:0] expv;
    expv = 8'b10000000;
    if_a.in_valid = 1'b1; if_a.in_data = 5'b00000;
    step();
    if_a.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (tx_a !== expv[i]) begin n_fail++; $display("FAIL zero_tx[%0d] got=%b exp=%b", i, tx_a, expv[i]); end
      // A valid that is offered while the line is busy must not be taken.
      if (i == 3) begin if_a.in_valid = 1'b1; if_a.in_data = 5'b11111; end
      if (i == 4) if_a.in_valid = 1'b0;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL zero_idle_busy[%0d] got=%b exp=0", i, busy_a); end
      n_chk++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL zero_idle_tx[%0d] got=%b exp=1", i, tx_a); end
      step();
    end
  endtask

  task automatic test_parity_modes();
    logic [7:0] exp_even, exp_odd;
    exp_even = 8'b11111110;
    exp_odd  = 8'b10111110;
    if_a.in_valid = 1'b1; if_a.in_data = 5'b11111;
    if_b.in_valid = 1'b1; if_b.in_data = 5'b11111;
    step();
    if_a.in_valid = 1'b0; if_b.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (tx_a !== exp_even[i]) begin n_fail++; $display("FAIL even11111_tx[%0d] got=%b exp=%b", i, tx_a, exp_even[i]); end
      n_chk++; if (tx_b !== exp_odd[i])  begin n_fail++; $display("FAIL odd11111_tx[%0d] got=%b exp=%b", i, tx_b, exp_odd[i]); end
      n_chk++; if (done_b !== (i == 7))  begin n_fail++; $display("FAIL odd11111_done[%0d] got=%b exp=%b", i, done_b, i == 7); end
      step();
    end
    n_chk++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL odd11111_busy_after got=%b exp=0", busy_b); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] words [3];
    logic [7:0] expv  [3];
    int f, s;
    words = '{5'b10110, 5'b00000, 5'b01101};
    expv  = '{8'b11101100, 8'b10000000, 8'b11011010};
    if_a.in_valid = 1'b1; if_a.in_data = words[0];
    step();
    for (int k = 0; k < 24; k++) begin
      f = k / 8; s = k % 8;
      n_chk++; if (tx_a !== expv[f][s]) begin n_fail++; $display("FAIL b2b_tx[%0d] got=%b exp=%b", k, tx_a, expv[f][s]); end
      n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d] got=%b exp=1", k, busy_a); end
      n_chk++; if (if_a.in_ready !== (s == 7)) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", k, if_a.in_ready, s == 7); end
      n_chk++; if (done_a !== (s == 7)) begin n_fail++; $display("FAIL b2b_done[%0d] got=%b exp=%b", k, done_a, s == 7); end
      if (s == 7) begin
        if (f < 2) if_a.in_data = words[f + 1];
        else       if_a.in_valid = 1'b0;
      end
      step();
    end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after got=%b exp=0", busy_a); end
    n_chk++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL b2b_tx_after got=%b exp=1", tx_a); end
  endtask

  task automatic test_bit_cycles4();
    logic [7:0] expv;
    int nk;
    expv = 8'b11000010;
    nk = FRAME_BITS(5) * 4;
    if_c.in_valid = 1'b1; if_c.in_data = 5'b00001;
    step();
    if_c.in_valid = 1'b0;
    for (int k = 0; k < nk; k++) begin
      n_chk++; if (tx_c !== expv[k / 4]) begin n_fail++; $display("FAIL bc4_tx[%0d] got=%b exp=%b", k, tx_c, expv[k / 4]); end
      n_chk++; if (busy_c !== 1'b1) begin n_fail++; $display("FAIL bc4_busy[%0d] got=%b exp=1", k, busy_c); end
      n_chk++; if (done_c !== (k == nk - 1)) begin n_fail++; $display("FAIL bc4_done[%0d] got=%b exp=%b", k, done_c, k == nk - 1); end
      n_chk++; if (if_c.in_ready !== (k == nk - 1)) begin n_fail++; $display("FAIL bc4_ready[%0d] got=%b exp=%b", k, if_c.in_ready, k == nk - 1); end
      step();
    end
    n_chk++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL bc4_busy_after got=%b exp=0", busy_c); end
    n_chk++; if (tx_c !== 1'b1)   begin n_fail++; $display("FAIL bc4_tx_after got=%b exp=1", tx_c); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] expv;
    expv = 8'b11101100;
    if_a.in_valid = 1'b1; if_a.in_data = 5'b11011;
    step();
    if_a.in_valid = 1'b0;
    repeat (3) step();
    n_chk++; if (tx_a !== 1'b0)   begin n_fail++; $display("FAIL midrst_pre_tx got=%b exp=0", tx_a); end
    n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got=%b exp=1", busy_a); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL midrst_tx got=%b exp=1", tx_a); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy_a); end
    n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done_a); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_chk++; if (if_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", if_a.in_ready); end
    n_chk++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_tx got=%b exp=1", tx_a); end
    if_a.in_valid = 1'b1; if_a.in_data = 5'b10110;
    step();
    if_a.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (tx_a !== expv[i]) begin n_fail++; $display("FAIL midrst_next_tx[%0d] got=%b exp=%b", i, tx_a, expv[i]); end
      step();
    end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_next_busy_after got=%b exp=0", busy_a); end
  endtask

  initial begin
    if_a.in_valid = 1'b0; if_a.in_data = 5'b00000;
    if_b.in_valid = 1'b0; if_b.in_data = 5'b00000;
    if_c.in_valid = 1'b0; if_c.in_data = 5'b00000;
    test_reset();
    test_frame_10110();
    test_frame_zero();
    test_parity_modes();
    test_back_to_back();
    test_bit_cycles4();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
